// File: rtl/syn_rst_seq_pkg.sv
// Shared types and register map for the reset sequencer.
package syn_rst_seq_pkg;

  typedef enum logic {
    SEQ  = 1'b0,
    DONE = 1'b1
  } seq_state_e;

  localparam int CTRL_ADDR      = 0;
  localparam int STATUS_ADDR    = 1;
  localparam int HOLD_BASE_ADDR = 2;

  localparam int STATUS_DONE_BIT = 0;
  localparam int STATUS_DOM_LSB  = 8;
  localparam int STATUS_IDX_LSB  = 16;
  localparam int STATUS_IDX_W    = 4;

endpackage

// File: rtl/syn_rst_seq_lb_regs.sv
// Local-bus register file: HOLD storage, CTRL soft-reset decode, acks and read mux.
module syn_rst_seq_lb_regs
  import syn_rst_seq_pkg::*;
#(
  parameter int              NUM_DOM   = 3,
  parameter int              CNT_W     = 16,
  parameter logic [CNT_W-1:0] DEF_HOLD = 16'd64,
  parameter int              LB_DATA_W = 32,
  parameter int              LB_ADDR_W = 4,
  parameter int              IDX_W     = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            lb_wr_en,
  input  logic                            lb_rd_en,
  input  logic [LB_ADDR_W-1:0]            lb_addr,
  input  logic [LB_DATA_W-1:0]            lb_wr_data,
  output logic                            lb_wr_valid,
  output logic                            lb_rd_valid,
  output logic [LB_DATA_W-1:0]            lb_rd_data,
  input  logic                            seq_done,
  input  logic [NUM_DOM-1:0]              dom_rst_n,
  input  logic [IDX_W-1:0]                idx,
  output logic [NUM_DOM-1:0][CNT_W-1:0]   hold,
  output logic                            soft_trig
);

  logic [NUM_DOM-1:0][CNT_W-1:0] hold_q, hold_d;
  logic                          wr_valid_q, wr_valid_d;
  logic                          rd_valid_q, rd_valid_d;
  logic [LB_DATA_W-1:0]          rd_data_q, rd_data_d;

  // Reads use the pre-write register values, so a same-cycle read/write returns old data.
  always_comb begin
    hold_d     = hold_q;
    wr_valid_d = lb_wr_en;
    rd_valid_d = lb_rd_en;
    rd_data_d  = rd_data_q;
    soft_trig  = 1'b0;

    if (lb_wr_en) begin
      if (lb_addr == LB_ADDR_W'(CTRL_ADDR)) begin
        soft_trig = lb_wr_data[0];
      end
      for (int i = 0; i < NUM_DOM; i++) begin
        if (lb_addr == LB_ADDR_W'(HOLD_BASE_ADDR + i)) begin
          hold_d[i] = lb_wr_data[CNT_W-1:0];
        end
      end
    end

    if (lb_rd_en) begin
      rd_data_d = '0;
      if (lb_addr == LB_ADDR_W'(STATUS_ADDR)) begin
        rd_data_d[STATUS_DONE_BIT]                = seq_done;
        rd_data_d[STATUS_DOM_LSB +: NUM_DOM]      = dom_rst_n;
        rd_data_d[STATUS_IDX_LSB +: STATUS_IDX_W] = STATUS_IDX_W'(idx);
      end
      for (int i = 0; i < NUM_DOM; i++) begin
        if (lb_addr == LB_ADDR_W'(HOLD_BASE_ADDR + i)) begin
          rd_data_d[CNT_W-1:0] = hold_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        hold_q[i] <= DEF_HOLD;
      end
      wr_valid_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      hold_q     <= hold_d;
      wr_valid_q <= wr_valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  generate
    if (LB_DATA_W > CNT_W) begin : g_unused_bits
      logic unused_wr_bits;
      assign unused_wr_bits = ^lb_wr_data[LB_DATA_W-1:CNT_W];
    end
  endgenerate

  assign hold        = hold_q;
  assign lb_wr_valid = wr_valid_q;
  assign lb_rd_valid = rd_valid_q;
  assign lb_rd_data  = rd_data_q;

endmodule

// File: rtl/syn_rst_seq.sv
// Ordered, re-triggerable reset sequencer: releases NUM_DOM resets one by one after programmable holds.
module syn_rst_seq
  import syn_rst_seq_pkg::*;
#(
  parameter int               NUM_DOM   = 3,
  parameter int               CNT_W     = 16,
  parameter logic [CNT_W-1:0] DEF_HOLD  = 16'd64,
  parameter int               LB_DATA_W = 32,
  parameter int               LB_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ext_rst_req_n,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0] lb_addr,
  input  logic [LB_DATA_W-1:0] lb_wr_data,
  output logic                 lb_wr_valid,
  output logic                 lb_rd_valid,
  output logic [LB_DATA_W-1:0] lb_rd_data,
  output logic [NUM_DOM-1:0]   dom_rst_n,
  output logic                 seq_done
);

  localparam int IDX_W = $clog2(NUM_DOM + 1);

  seq_state_e                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_DOM-1:0]            dom_rst_n_q, dom_rst_n_d;
  logic                          seq_done_q, seq_done_d;
  logic [NUM_DOM-1:0][CNT_W-1:0] hold;
  logic [CNT_W-1:0]              cur_hold;
  logic                          soft_trig;
  logic                          restart;

  syn_rst_seq_lb_regs #(
    .NUM_DOM   (NUM_DOM),
    .CNT_W     (CNT_W),
    .DEF_HOLD  (DEF_HOLD),
    .LB_DATA_W (LB_DATA_W),
    .LB_ADDR_W (LB_ADDR_W),
    .IDX_W     (IDX_W)
  ) u_lb_regs (
    .clk         (clk),
    .rst_n       (rst_n),
    .lb_wr_en    (lb_wr_en),
    .lb_rd_en    (lb_rd_en),
    .lb_addr     (lb_addr),
    .lb_wr_data  (lb_wr_data),
    .lb_wr_valid (lb_wr_valid),
    .lb_rd_valid (lb_rd_valid),
    .lb_rd_data  (lb_rd_data),
    .seq_done    (seq_done_q),
    .dom_rst_n   (dom_rst_n_q),
    .idx         (idx_q),
    .hold        (hold),
    .soft_trig   (soft_trig)
  );

  assign restart = ~ext_rst_req_n | soft_trig;

  always_comb begin
    cur_hold = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_hold = hold[i];
      end
    end
  end

  // A HOLD smaller than the running count is not clamped; the counter wraps before matching.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    dom_rst_n_d = dom_rst_n_q;
    seq_done_d  = seq_done_q;

    if (restart) begin
      state_d     = SEQ;
      idx_d       = '0;
      cnt_d       = '0;
      dom_rst_n_d = '0;
      seq_done_d  = 1'b0;
    end else if (state_q == SEQ) begin
      if (cnt_q == cur_hold) begin
        for (int i = 0; i < NUM_DOM; i++) begin
          if (idx_q == IDX_W'(i)) begin
            dom_rst_n_d[i] = 1'b1;
          end
        end
        idx_d = idx_q + IDX_W'(1);
        cnt_d = '0;
        if (idx_q == IDX_W'(NUM_DOM - 1)) begin
          state_d    = DONE;
          seq_done_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SEQ;
      idx_q       <= '0;
      cnt_q       <= '0;
      dom_rst_n_q <= '0;
      seq_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      dom_rst_n_q <= dom_rst_n_d;
      seq_done_q  <= seq_done_d;
    end
  end

  assign dom_rst_n = dom_rst_n_q;
  assign seq_done  = seq_done_q;

endmodule

// File: tb/tb_syn_rst_seq.sv
// Directed self-checking bench for syn_rst_seq (NUM_DOM=3, default parameters).
module tb_syn_rst_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_rst_req_n;
  logic        lb_wr_en;
  logic        lb_rd_en;
  logic [3:0]  lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid;
  logic        lb_rd_valid;
  logic [31:0] lb_rd_data;
  logic [2:0]  dom_rst_n;
  logic        seq_done;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  syn_rst_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ext_rst_req_n (ext_rst_req_n),
    .lb_wr_en      (lb_wr_en),
    .lb_rd_en      (lb_rd_en),
    .lb_addr       (lb_addr),
    .lb_wr_data    (lb_wr_data),
    .lb_wr_valid   (lb_wr_valid),
    .lb_rd_valid   (lb_rd_valid),
    .lb_rd_data    (lb_rd_data),
    .dom_rst_n     (dom_rst_n),
    .seq_done      (seq_done)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One bus transaction held for exactly one sampling edge.
  task automatic applyStimulus(input logic wr, input logic rd, input logic [3:0] addr, input logic [31:0] data);
    lb_wr_en   = wr;
    lb_rd_en   = rd;
    lb_addr    = addr;
    lb_wr_data = data;
    tick(1);
    lb_wr_en   = 1'b0;
    lb_rd_en   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n         = 1'b0;
    ext_rst_req_n = 1'b1;
    lb_wr_en      = 1'b0;
    lb_rd_en      = 1'b0;
    lb_addr       = '0;
    lb_wr_data    = '0;

    // Reset state
    tick(3);
    checkOutput("rst_dom",      32'(dom_rst_n),   32'h0);
    checkOutput("rst_done",     32'(seq_done),    32'h0);
    checkOutput("rst_wr_valid", 32'(lb_wr_valid), 32'h0);
    checkOutput("rst_rd_valid", 32'(lb_rd_valid), 32'h0);
    checkOutput("rst_rd_data",  lb_rd_data,       32'h0);

    // Power-up with default holds of 64: releases at edges 65, 130, 195
    rst_n = 1'b1;
    tick(64);
    checkOutput("pwr_e64",  32'(dom_rst_n), 32'h0);
    tick(1);
    checkOutput("pwr_e65",  32'(dom_rst_n), 32'h1);
    tick(64);
    checkOutput("pwr_e129", 32'(dom_rst_n), 32'h1);
    tick(1);
    checkOutput("pwr_e130", 32'(dom_rst_n), 32'h3);
    tick(64);
    checkOutput("pwr_e194", 32'(dom_rst_n), 32'h3);
    checkOutput("pwr_done_e194", 32'(seq_done), 32'h0);
    tick(1);
    checkOutput("pwr_e195", 32'(dom_rst_n), 32'h7);
    checkOutput("pwr_done_e195", 32'(seq_done), 32'h1);
    tick(3);
    checkOutput("pwr_hold_done", 32'(dom_rst_n), 32'h7);

    // Local bus protocol
    applyStimulus(1'b0, 1'b1, 4'h1, 32'h0);
    checkOutput("status_valid", 32'(lb_rd_valid), 32'h1);
    checkOutput("status_data",  lb_rd_data,       32'h0003_0701);
    checkOutput("status_wr_valid", 32'(lb_wr_valid), 32'h0);
    tick(1);
    checkOutput("rd_valid_pulse", 32'(lb_rd_valid), 32'h0);
    checkOutput("rd_data_held",   lb_rd_data,       32'h0003_0701);
    applyStimulus(1'b0, 1'b1, 4'hF, 32'h0);
    checkOutput("unmapped_valid", 32'(lb_rd_valid), 32'h1);
    checkOutput("unmapped_data",  lb_rd_data,       32'h0);
    applyStimulus(1'b1, 1'b0, 4'h3, 32'h0000_1234);
    checkOutput("wr_valid_on",  32'(lb_wr_valid), 32'h1);
    tick(1);
    checkOutput("wr_valid_off", 32'(lb_wr_valid), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h3, 32'h0);
    checkOutput("hold1_rd", lb_rd_data, 32'h0000_1234);
    applyStimulus(1'b1, 1'b1, 4'h3, 32'h0000_0003);
    checkOutput("rdwr_old", lb_rd_data, 32'h0000_1234);
    checkOutput("rdwr_ack", 32'(lb_wr_valid), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'h3, 32'h0);
    checkOutput("hold1_new", lb_rd_data, 32'h0000_0003);
    checkOutput("done_after_writes", 32'(dom_rst_n), 32'h7);

    // Programmed holds 0/3/10 then soft trigger: releases at +1, +5, +16
    applyStimulus(1'b1, 1'b0, 4'h2, 32'd0);
    applyStimulus(1'b1, 1'b0, 4'h4, 32'd10);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h1);
    checkOutput("soft_clear",      32'(dom_rst_n), 32'h0);
    checkOutput("soft_done_clear", 32'(seq_done),  32'h0);
    tick(1);
    checkOutput("soft_p1",  32'(dom_rst_n), 32'h1);
    tick(3);
    checkOutput("soft_p4",  32'(dom_rst_n), 32'h1);
    tick(1);
    checkOutput("soft_p5",  32'(dom_rst_n), 32'h3);
    tick(10);
    checkOutput("soft_p15", 32'(dom_rst_n), 32'h3);
    tick(1);
    checkOutput("soft_p16", 32'(dom_rst_n), 32'h7);
    checkOutput("soft_done", 32'(seq_done), 32'h1);
    applyStimulus(1'b0, 1'b1, 4'h1, 32'h0);
    checkOutput("soft_status", lb_rd_data, 32'h0003_0701);
    applyStimulus(1'b0, 1'b1, 4'h0, 32'h0);
    checkOutput("ctrl_reads0", lb_rd_data, 32'h0);

    // External request mid-sequence, HOLD_0=5
    applyStimulus(1'b1, 1'b0, 4'h2, 32'd5);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h1);
    tick(5);
    checkOutput("ext_pre_p5", 32'(dom_rst_n), 32'h0);
    tick(1);
    checkOutput("ext_pre_p6", 32'(dom_rst_n), 32'h1);
    tick(2);
    ext_rst_req_n = 1'b0;
    tick(1);
    checkOutput("ext_clear", 32'(dom_rst_n), 32'h0);
    tick(19);
    checkOutput("ext_held",  32'(dom_rst_n), 32'h0);
    ext_rst_req_n = 1'b1;
    tick(5);
    checkOutput("ext_rel_p5", 32'(dom_rst_n), 32'h0);
    tick(1);
    checkOutput("ext_rel_p6", 32'(dom_rst_n), 32'h1);

    // Soft trigger while counting toward domain 1
    tick(1);
    applyStimulus(1'b0, 1'b1, 4'h1, 32'h0);
    checkOutput("idx1_status", lb_rd_data, 32'h0001_0100);
    applyStimulus(1'b1, 1'b0, 4'h0, 32'h1);
    checkOutput("idx1_trig_clear", 32'(dom_rst_n), 32'h0);
    applyStimulus(1'b0, 1'b1, 4'h1, 32'h0);
    checkOutput("idx1_status_after", lb_rd_data, 32'h0);
    tick(4);
    checkOutput("idx1_p5",  32'(dom_rst_n), 32'h0);
    tick(1);
    checkOutput("idx1_p6",  32'(dom_rst_n), 32'h1);
    tick(4);
    checkOutput("idx1_p10", 32'(dom_rst_n), 32'h3);

    // rst_n mid-sequence restores everything including HOLD registers
    rst_n = 1'b0;
    tick(1);
    checkOutput("midrst_dom",  32'(dom_rst_n),   32'h0);
    checkOutput("midrst_done", 32'(seq_done),    32'h0);
    checkOutput("midrst_rd",   lb_rd_data,       32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'h3, 32'h0);
    checkOutput("midrst_hold1", lb_rd_data, 32'h0000_0040);
    applyStimulus(1'b0, 1'b1, 4'h2, 32'h0);
    checkOutput("midrst_hold0", lb_rd_data, 32'h0000_0040);
    tick(62);
    checkOutput("midrst_e64", 32'(dom_rst_n), 32'h0);
    tick(1);
    checkOutput("midrst_e65", 32'(dom_rst_n), 32'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
